// File: rtl/dcache_wb_if.sv
// Bus bundle for dcache_wb: the CPU request/response channel and the line-granular memory channel.
// The cache connects through the slave modport; the CPU/memory environment uses master.
interface dcache_wb_if #(
  parameter int AW    = 17,
  parameter int DW    = 32,
  parameter int WORDS = 16
);
  localparam int OB = $clog2(WORDS);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [AW-1:0]         req_addr;
  logic [DW-1:0]         req_wdata;
  logic                  rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [AW-OB-1:0]      mem_addr;
  logic [WORDS*DW-1:0]   mem_wdata;
  logic                  mem_rsp_valid;
  logic [WORDS*DW-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with whole-line memory transfers.
// Optional hit/miss counters are built when DCACHE_WB_STATS_EN is defined.
module dcache_wb #(
  parameter int AW    = 17,
  parameter int DW    = 32,
  parameter int LINES = 1024,
  parameter int WORDS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_wb_if.slave    bus
`ifdef DCACHE_WB_STATS_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = AW - IB - OB;
  localparam int LW = WORDS * DW;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FETCH, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, dirty_q;
  logic [TB-1:0]     tag_q  [LINES];
  logic [LW-1:0]     data_q [LINES];

  logic [AW-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-OB-1:0]  mem_addr_q, mem_addr_d;
  logic [LW-1:0]     mem_wdata_q, mem_wdata_d;

  logic [TB-1:0]     req_tag, lat_tag;
  logic [IB-1:0]     req_idx, lat_idx;
  logic [OB-1:0]     req_off, lat_off;
  logic [LW-1:0]     req_line, lat_line, fill_line;
  logic              accept, hit, victim_dirty, install, hit_wr;

  assign req_tag  = bus.req_addr[AW-1:IB+OB];
  assign req_idx  = bus.req_addr[IB+OB-1:OB];
  assign req_off  = bus.req_addr[OB-1:0];
  assign lat_tag  = addr_q[AW-1:IB+OB];
  assign lat_idx  = addr_q[IB+OB-1:OB];
  assign lat_off  = addr_q[OB-1:0];
  assign req_line = data_q[req_idx];
  assign lat_line = data_q[lat_idx];

  assign bus.req_ready = rst_n && (state_q == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign hit           = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty  = valid_q[req_idx] && dirty_q[req_idx];
  assign install       = (state_q == S_WAIT) && bus.mem_rsp_valid;
  assign hit_wr        = accept && hit && bus.req_we;

  // A write miss installs the fetched line with the requested word already merged.
  always_comb begin
    fill_line = bus.mem_rdata;
    if (we_q) fill_line[lat_off*DW +: DW] = wdata_q;
  end

  // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    wdata_d         = wdata_q;
    rsp_valid_d     = 1'b0;
    rsp_rdata_d     = rsp_rdata_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus.req_we ? bus.req_wdata : req_line[req_off*DW +: DW];
          end else if (victim_dirty) begin
            state_d         = S_WB;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b1;
            mem_addr_d      = {tag_q[req_idx], req_idx};
            mem_wdata_d     = req_line;
          end else begin
            state_d         = S_FETCH;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b0;
            mem_addr_d      = bus.req_addr[AW-1:OB];
          end
        end
      end
      S_WB: begin
        // Request stays asserted straight through into the fetch of the missing line.
        if (bus.mem_req_ready) begin
          state_d    = S_FETCH;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q[AW-1:OB];
        end
      end
      S_FETCH: begin
        if (bus.mem_req_ready) begin
          state_d         = S_WAIT;
          mem_req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) state_d = S_RESP;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = lat_line[lat_off*DW +: DW];
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      wdata_q         <= wdata_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (install) begin
        valid_q[lat_idx] <= 1'b1;
        dirty_q[lat_idx] <= we_q;
      end
      if (hit_wr) dirty_q[req_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether contents count.
  always_ff @(posedge clk) begin
    if (hit_wr) begin
      data_q[req_idx][req_off*DW +: DW] <= bus.req_wdata;
    end else if (install) begin
      data_q[lat_idx] <= fill_line;
      tag_q[lat_idx]  <= lat_tag;
    end
  end

`ifdef DCACHE_WB_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboarded bench for dcache_wb: a flat word-memory reference model predicts every read,
// a line-residency model predicts hits and latencies, and a behavioural memory serves lines.
module tb_dcache_wb;
  localparam int AW = 17, DW = 32, LINES = 1024, WORDS = 16;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    int          lat;
    int          acc;
  } item_t;

  logic clk, rst_n;
  dcache_wb_if #(.AW(AW), .DW(DW), .WORDS(WORDS)) bus ();

`ifdef DCACHE_WB_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  dcache_wb #(.AW(AW), .DW(DW), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt));
`else
  dcache_wb #(.AW(AW), .DW(DW), .LINES(LINES), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_rsp = 0, mem_req_cycles = 0;
  item_t exp_q[$];

  // Reference state: backing memory, words written since reset, resident line per index.
  logic [511:0] mem_lines [int];
  logic [31:0]  ref_wr [int];
  bit           res_v [LINES];
  bit           res_d [LINES];
  logic [2:0]   res_t [LINES];

  logic         log_we[$];
  logic [12:0]  log_addr[$];
  logic [511:0] log_data[$];

  bit zw, hold_rsp;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] init_line(input int la);
    logic [511:0] l;
    logic [31:0] h;
    for (int w = 0; w < WORDS; w++) begin
      h = 32'(la) * 32'h9E3779B1 ^ 32'(w) * 32'h85EBCA6B ^ 32'h5A5A0001;
      if (la == 2) h = 32'h0;
      else if (la == 1 && w == 0) h = 32'hAAAA0000;
      l[w*32 +: 32] = h;
    end
    return l;
  endfunction

  function automatic logic [511:0] get_line(input int la);
    if (!mem_lines.exists(la)) mem_lines[la] = init_line(la);
    return mem_lines[la];
  endfunction

  function automatic logic [31:0] ref_word(input logic [16:0] a);
    logic [511:0] l;
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    l = get_line(int'(a[16:4]));
    return l[int'(a[3:0])*32 +: 32];
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every response pops the oldest expectation.
  always @(negedge clk) begin
    item_t it;
    if (bus.rsp_valid) n_rsp++;
    if (rst_n) begin
      if (bus.mem_req_valid) mem_req_cycles++;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          it = exp_q.pop_front();
          check($sformatf("rdata@%05h", it.addr), bus.rsp_rdata, it.data);
          if (it.lat >= 0) check($sformatf("latency@%05h", it.addr), cyc - it.acc, it.lat);
        end
      end
    end
  end

  // Memory: serves fetches, absorbs writebacks, occasionally pulses a stray mem_rsp_valid.
  bit           prev_hs, prev_we, pend;
  logic [12:0]  prev_addr, pend_addr;
  logic [511:0] prev_wdata, exp_line;
  int           pend_dly;
  initial begin
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
    prev_hs = 0; pend = 0;
    forever begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 0; prev_hs = 0; bus.mem_req_ready = 1'b0;
      end else begin
        if (prev_hs) begin
          log_we.push_back(prev_we); log_addr.push_back(prev_addr); log_data.push_back(prev_wdata);
          if (prev_we) begin
            for (int w = 0; w < WORDS; w++) exp_line[w*32 +: 32] = ref_word({prev_addr, 4'(w)});
            check($sformatf("wb_line@%03h", prev_addr), prev_wdata, exp_line);
            mem_lines[int'(prev_addr)] = prev_wdata;
          end else begin
            pend = 1; pend_addr = prev_addr; pend_dly = zw ? 0 : $urandom_range(0, 3);
          end
        end
        if (pend && !hold_rsp) begin
          if (pend_dly == 0) begin
            bus.mem_rsp_valid = 1'b1; bus.mem_rdata = get_line(int'(pend_addr)); pend = 0;
          end else pend_dly--;
        end else if (!pend && !zw && $urandom_range(0, 15) == 0) begin
          bus.mem_rsp_valid = 1'b1;
          for (int w = 0; w < WORDS; w++) bus.mem_rdata[w*32 +: 32] = $urandom;
        end
        bus.mem_req_ready = bus.mem_req_valid && (zw || $urandom_range(0, 2) != 0);
        prev_hs    = bus.mem_req_valid && bus.mem_req_ready;
        prev_we    = bus.mem_we;
        prev_addr  = bus.mem_addr;
        prev_wdata = bus.mem_wdata;
      end
    end
  end

  // Drives one request from a falling edge; leaves req_valid high for back-to-back issue.
  task automatic issue(input logic [16:0] a, input logic we, input logic [31:0] wd);
    int t = 0;
    item_t it;
    int idx;
    bit h;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    while (!bus.req_ready && t < 1000) begin @(negedge clk); t++; end
    if (!bus.req_ready) begin
      check("accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    idx = int'(a[13:4]);
    h = res_v[idx] && res_t[idx] == a[16:14];
    it.lat = h ? 1 : (zw ? ((res_v[idx] && res_d[idx]) ? 5 : 4) : -1);
    if (!h) res_d[idx] = 0;
    if (we) res_d[idx] = 1;
    res_v[idx] = 1; res_t[idx] = a[16:14];
    it.addr = a; it.acc = cyc;
    it.data = we ? wd : ref_word(a);
    if (we) ref_wr[int'(a)] = wd;
    exp_q.push_back(it);
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    bus.req_valid = 1'b0;
    while (exp_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete();
  endtask

  initial begin
    int t, rsp0;
    logic [511:0] l;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    zw = 1; hold_rsp = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef DCACHE_WB_STATS_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read: one fetch of line 0x001, response after 4 cycles.
    clear_log();
    issue(17'h00010, 0, 0);
    drain();
    check("cold_nreq", log_we.size(), 1);
    if (log_we.size() >= 1) begin
      check("cold_fetch_we", log_we[0], 0);
      check("cold_fetch_addr", log_addr[0], 13'h001);
    end

    // Repeat read hits without touching memory.
    mem_req_cycles = 0;
    issue(17'h00010, 0, 0);
    drain();
    check("hit_no_mem", mem_req_cycles, 0);

    // Write hit dirties line 1; conflicting read evicts it.
    clear_log();
    issue(17'h00012, 1, 32'hDEADBEEF);
    issue(17'h04010, 0, 0);
    drain();
    check("evict_nreq", log_we.size(), 2);
    if (log_we.size() >= 2) begin
      l = log_data[0];
      check("evict_wb_we", log_we[0], 1);
      check("evict_wb_addr", log_addr[0], 13'h001);
      check("evict_wb_word2", l[2*32 +: 32], 32'hDEADBEEF);
      check("evict_fetch_we", log_we[1], 0);
      check("evict_fetch_addr", log_addr[1], 13'h401);
    end
`ifdef DCACHE_WB_STATS_EN
    check("stats_hit_cnt", hit_cnt, 2);
    check("stats_miss_cnt", miss_cnt, 2);
`endif

    // Cold write-allocate into an all-zero line, then hit on it and a neighbour.
    issue(17'h00025, 1, 32'h12345678);
    issue(17'h00025, 0, 0);
    issue(17'h00024, 0, 0);
    drain();

    // Reset while waiting for fetch data abandons the miss.
    clear_log();
    hold_rsp = 1;
    issue(17'h08030, 0, 0);
    bus.req_valid = 1'b0;
    t = 0;
    while (log_we.size() == 0 && t < 100) begin @(negedge clk); t++; end
    check("wait_fetch_seen", log_we.size(), 1);
    repeat (2) @(negedge clk);
    rsp0 = n_rsp;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req_valid", bus.mem_req_valid, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    repeat (3) @(negedge clk);
    exp_q.delete(); ref_wr.delete();
    for (int i = 0; i < LINES; i++) res_v[i] = 0;
    hold_rsp = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_rsp", n_rsp, rsp0);
    clear_log();
    issue(17'h08030, 0, 0);
    drain();
    check("rerd_nreq", log_we.size(), 1);
    if (log_we.size() >= 1) check("rerd_fetch_addr", log_addr[0], 13'h803);
    issue(17'h00025, 0, 0);
    drain();

    // Random traffic over four indices and eight tags with a stalling memory.
    zw = 0;
    for (int i = 0; i < 400; i++) begin
      issue({3'($urandom), 8'h00, 2'($urandom), 4'($urandom)}, 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 Parameter AW, default 17: word-address width.
REQ-002 Parameter DW, default 32: data word width.
REQ-003 Parameter LINES, default 1024: cache lines, power of two.
REQ-004 Parameter WORDS, default 16: words per line, power of two; OB=log2(WORDS), IB=log2(LINES), TB=AW-IB-OB.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  CPU request present.
REQ-008 req_ready  out  1  block accepts request this cycle.
REQ-009 req_we  in  1  1=write, 0=read.
REQ-010 req_addr  in  AW  word address: tag[AW-1:IB+OB], index[IB+OB-1:OB], offset[OB-1:0].
REQ-011 req_wdata  in  DW  write word.
REQ-012 rsp_valid  out  1  one-cycle response pulse.
REQ-013 rsp_rdata  out  DW  read word, or merged write word for writes.
REQ-014 mem_req_valid / mem_req_ready  out/in  1  memory request handshake.
REQ-015 mem_we  out  1  1=line writeback, 0=line fetch.
REQ-016 mem_addr  out  AW-OB  line address.
REQ-017 mem_wdata  out  WORDS*DW  writeback line, word 0 in LSBs.
REQ-018 mem_rsp_valid  in  1  fetch data valid; mem_rdata  in  WORDS*DW  fetched line.

Function
REQ-019 Direct-mapped, write-back, write-allocate; per-line valid bit, dirty bit, TB-bit tag.
REQ-020 FSM states IDLE, WB, FETCH, WAIT, RESP; req_ready=1 only in IDLE.
REQ-021 Request accepted on req_valid&&req_ready; addr/we/wdata latched at acceptance.
REQ-022 Hit (valid && tag equal) in IDLE: read -> rsp_valid next cycle with stored word; write -> word updated, dirty=1, rsp_valid next cycle; FSM stays IDLE, back-to-back hits sustain one per cycle.
REQ-023 Miss with dirty victim: IDLE->WB; mem_req_valid=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim line, held until mem_req_ready; then ->FETCH.
REQ-024 Miss with clean or invalid victim: IDLE->FETCH directly; no writeback issued.
REQ-025 FETCH: mem_req_valid=1, mem_we=0, mem_addr={req tag,index} until mem_req_ready; then ->WAIT.
REQ-026 WAIT: on mem_rsp_valid install mem_rdata, valid=1, tag=req tag, dirty=0; for write, requested word replaced by latched wdata and dirty=1; ->RESP.
REQ-027 RESP: rsp_valid=1 one cycle with requested word; ->IDLE.
REQ-028 mem_rsp_valid outside WAIT ignored; mem_req_valid never dropped before handshake.
REQ-029 Miss latency with zero-wait memory: clean miss 4 cycles acceptance-to-rsp_valid, dirty miss 5.

Reset
REQ-030 rst_n low: FSM=IDLE, all valid and dirty cleared, rsp_valid=0, rsp_rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, req_ready=0 while asserted.
REQ-031 Reset mid-WB/FETCH/WAIT abandons the transaction; dirty data lost; no partial install.
REQ-032 Data and tag arrays not reset.

Configuration
REQ-033 Macro DCACHE_WB_STATS_EN defined: outputs hit_cnt and miss_cnt, 32 bits, count accepted requests, saturate at all-ones, cleared by reset.
REQ-034 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-035 Cold read 0x00010, mem_rdata word0=0xAAAA0000 -> FETCH mem_addr=0x001, rsp_rdata=0xAAAA0000 after 4 cycles with zero-wait memory.
REQ-036 Repeat read 0x00010 -> rsp_valid next cycle, 0xAAAA0000, no mem_req_valid.
REQ-037 Write 0x00012 data 0xDEADBEEF (hit), then read 0x04010 -> WB mem_addr=0x001 with word2=0xDEADBEEF, then FETCH mem_addr=0x401.
REQ-038 Cold write 0x00025 data 0x12345678, fetched line all zero -> rsp_rdata=0x12345678; later read 0x00025 hits with 0x12345678, read 0x00024 returns 0.
REQ-039 rst_n low during WAIT -> mem_req_valid=0, rsp_valid never pulses; re-read same address misses.
REQ-040 With DCACHE_WB_STATS_EN: sequence REQ-035..037 -> hit_cnt=2, miss_cnt=2.
